// File: rtl/conv_pkg.sv
// Shared helpers for conv2d_stream: clog2, port/counter width derivation and the accumulator-width legality rule.
// Pure functions only; no latency, no flow control.
package conv_pkg;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction

  // Width of a field that must hold 0..n-1, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (clog2(n) < 1) ? 1 : clog2(n);
  endfunction

  // Coefficient address covers K*K taps plus the bias slot.
  function automatic int addr_w(input int k);
    return cnt_w(k * k + 1);
  endfunction

  function automatic bit acc_w_ok(input int acc_w, input int data_w, input int coef_w, input int k);
    return acc_w >= data_w + coef_w + clog2(k * k) + 1;
  endfunction

endpackage

// File: rtl/conv_line_buffer.sv
// K-1 cascaded IMG_W-deep pixel rows sharing one enable; taps[r] is the pixel r rows above din.
// Taps are combinational from din (zero latency); shifts only when en is high, no backpressure.
module conv_line_buffer #(
  parameter int DATA_W = 16,
  parameter int K      = 5,
  parameter int IMG_W  = 28
) (
  input  logic                        clk,
  input  logic                        en,
  input  logic [DATA_W-1:0]           din,
  output logic [K-1:0][DATA_W-1:0]    taps
);

  logic [DATA_W-1:0] row_q [K-1][IMG_W];

  // Contents are don't-care after reset, so the rows carry no reset.
  always_ff @(posedge clk) begin
    if (en) begin
      for (int r = 0; r < K - 1; r++) begin
        row_q[r][0] <= (r == 0) ? din : row_q[(r == 0) ? 0 : r - 1][IMG_W-1];
        for (int c = 1; c < IMG_W; c++) row_q[r][c] <= row_q[r][c-1];
      end
    end
  end

  always_comb begin
    taps[0] = din;
    for (int r = 0; r < K - 1; r++) taps[r+1] = row_q[r][IMG_W-1];
  end

endmodule

// File: rtl/conv2d_stream.sv
// Raster-order KxK "valid" convolution with runtime coefficients; define CONV2D_RELU_EN to clamp results at zero.
// Latency 3 cycles (window, products, adder tree) from the completing pixel; never stalls, no backpressure.
module conv2d_stream
  import conv_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int COEF_W = 16,
  parameter int K      = 5,
  parameter int IMG_W  = 28,
  parameter int IMG_H  = 28,
  parameter int ACC_W  = 40
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  input  logic signed [DATA_W-1:0]  in_data,
  input  logic                      w_we,
  input  logic [addr_w(K)-1:0]      w_addr,
  input  logic signed [COEF_W-1:0]  w_data,
  output logic                      w_err,
  output logic                      busy,
  output logic                      out_valid,
  output logic signed [ACC_W-1:0]   out_data,
  output logic                      frame_done
);

  localparam int NT = K * K;
  localparam int AW = addr_w(K);
  localparam int PW = DATA_W + COEF_W;
  localparam int CW = cnt_w(IMG_W);
  localparam int RW = cnt_w(IMG_H);
  localparam logic [AW-1:0] BIAS_ADDR = AW'(NT);

  if (!acc_w_ok(ACC_W, DATA_W, COEF_W, K)) begin : g_acc_chk
    $error("conv2d_stream: ACC_W too narrow for DATA_W, COEF_W and K");
  end

  logic signed [COEF_W-1:0] coef_q [NT+1];
  logic [CW-1:0] col_q;
  logic [RW-1:0] row_q;
  logic w_ok, col_last, row_last, first_pix, win_done;
  logic v1_q, l1_q, v2_q, l2_q;

  assign w_ok      = w_we && !busy && (w_addr <= BIAS_ADDR);
  assign col_last  = (col_q == CW'(IMG_W - 1));
  assign row_last  = (row_q == RW'(IMG_H - 1));
  assign first_pix = in_valid && (col_q == '0) && (row_q == '0);
  assign win_done  = in_valid && (row_q >= RW'(K - 1)) && (col_q >= CW'(K - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i <= NT; i++) coef_q[i] <= '0;
      w_err <= 1'b0;
    end else begin
      w_err <= w_we && !w_ok;
      if (w_ok) coef_q[w_addr] <= w_data;
    end
  end

  logic [K-1:0][DATA_W-1:0] taps;

  conv_line_buffer #(.DATA_W(DATA_W), .K(K), .IMG_W(IMG_W)) u_lbuf (
    .clk  (clk),
    .en   (in_valid),
    .din  (in_data),
    .taps (taps)
  );

  // Stage 1: window row i holds image row (row-K+1+i); column K-1 is the newest pixel.
  logic signed [DATA_W-1:0] win_q [NT];

  always_ff @(posedge clk) begin
    if (in_valid) begin
      for (int i = 0; i < K; i++) begin
        for (int j = 0; j < K - 1; j++) win_q[i*K+j] <= win_q[i*K+j+1];
        win_q[i*K+K-1] <= $signed(taps[K-1-i]);
      end
    end
  end

  // Stage 2 products, then a bias-seeded chain of adds feeding stage 3.
  for (genvar n = 0; n < NT; n++) begin : g_tap
    logic signed [PW-1:0]    px, cx, prod_q;
    logic signed [ACC_W-1:0] acc;
    assign px = PW'(win_q[n]);
    assign cx = PW'(coef_q[n]);
    always_ff @(posedge clk) prod_q <= px * cx;
    if (n == 0) begin : g_base
      assign acc = ACC_W'(coef_q[NT]) + ACC_W'(prod_q);
    end else begin : g_chain
      assign acc = g_tap[n-1].acc + ACC_W'(prod_q);
    end
  end

  logic signed [ACC_W-1:0] sum, res;
  assign sum = g_tap[NT-1].acc;
`ifdef CONV2D_RELU_EN
  assign res = sum[ACC_W-1] ? '0 : sum;
`else
  assign res = sum;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q      <= '0;
      row_q      <= '0;
      busy       <= 1'b0;
      v1_q       <= 1'b0;
      l1_q       <= 1'b0;
      v2_q       <= 1'b0;
      l2_q       <= 1'b0;
      out_valid  <= 1'b0;
      frame_done <= 1'b0;
      out_data   <= '0;
    end else begin
      v1_q       <= win_done;
      l1_q       <= in_valid && col_last && row_last;
      v2_q       <= v1_q;
      l2_q       <= l1_q;
      out_valid  <= v2_q;
      frame_done <= v2_q && l2_q;
      if (v2_q) out_data <= res;
      if (in_valid) begin
        col_q <= col_last ? '0 : col_q + CW'(1);
        if (col_last) row_q <= row_last ? '0 : row_q + RW'(1);
      end
      // A following frame already under way keeps busy (and the weights) locked.
      if (first_pix) busy <= 1'b1;
      else if (frame_done && (col_q == '0) && (row_q == '0)) busy <= 1'b0;
    end
  end

endmodule

// File: tb/tb_conv2d_stream.sv
// Randomized and directed frames for conv2d_stream checked against a plain-arithmetic convolution model.
// Output values, 3-cycle latency, frame_done placement, busy and w_err behaviour are all compared.
module tb_conv2d_stream;

  localparam int DATA_W = 16, COEF_W = 16, K = 5, IMG_W = 28, IMG_H = 28, ACC_W = 40;
  localparam int AW = 5;
  localparam int NT = K * K;
  localparam int OW = IMG_W - K + 1, OH = IMG_H - K + 1;
  localparam int NOUT = OW * OH, NPIX = IMG_W * IMG_H;
`ifdef CONV2D_RELU_EN
  localparam bit RELU = 1'b1;
`else
  localparam bit RELU = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic in_valid = 1'b0;
  logic w_we = 1'b0;
  logic signed [DATA_W-1:0] in_data = '0;
  logic [AW-1:0] w_addr = '0;
  logic signed [COEF_W-1:0] w_data = '0;
  logic w_err, busy, out_valid, frame_done;
  logic signed [ACC_W-1:0] out_data;

  conv2d_stream #(
    .DATA_W(DATA_W), .COEF_W(COEF_W), .K(K), .IMG_W(IMG_W), .IMG_H(IMG_H), .ACC_W(ACC_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .w_we(w_we), .w_addr(w_addr), .w_data(w_data), .w_err(w_err), .busy(busy),
    .out_valid(out_valid), .out_data(out_data), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  longint pix [NPIX];
  longint wts [NT];
  longint bias;
  longint exp_q [$];
  longint obs_d [$];
  int     obs_c [$];
  bit     obs_f [$];
  int     acc_c [$];
  int ncyc = 0, werr_cnt = 0, stray_fd = 0, busy_rise = -1, busy_fall = -1;
  bit busy_prev = 1'b0;
  int vectors = 0, miscompares = 0;

  // Observation log, sampled mid-cycle on the falling edge.
  always @(negedge clk) begin
    ncyc++;
    if (rst_n && in_valid) acc_c.push_back(ncyc);
    if (out_valid === 1'b1) begin
      obs_d.push_back(longint'(out_data));
      obs_c.push_back(ncyc);
      obs_f.push_back(frame_done);
    end else if (frame_done === 1'b1) stray_fd++;
    if (w_err === 1'b1) werr_cnt++;
    if (busy === 1'b1 && !busy_prev) busy_rise = ncyc;
    if (busy === 1'b0 && busy_prev) busy_fall = ncyc;
    busy_prev = (busy === 1'b1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    exp_q.delete(); obs_d.delete(); obs_c.delete(); obs_f.delete(); acc_c.delete();
    werr_cnt = 0; stray_fd = 0; busy_rise = -1; busy_fall = -1;
  endtask

  task automatic write_w(input int addr, input longint data);
    w_we = 1'b1;
    w_addr = AW'(addr);
    w_data = COEF_W'(data);
    tick();
    w_we = 1'b0;
  endtask

  task automatic load_all();
    for (int n = 0; n < NT; n++) write_w(n, wts[n]);
    write_w(NT, bias);
  endtask

  task automatic drive_frame(input int gap_max, input int npix);
    for (int p = 0; p < npix; p++) begin
      if (gap_max > 0) begin
        repeat ($urandom_range(0, gap_max)) begin
          in_valid = 1'b0;
          tick();
        end
      end
      in_valid = 1'b1;
      in_data = DATA_W'(pix[p]);
      tick();
    end
    in_valid = 1'b0;
  endtask

  // Reference: direct definition of each valid-window output, raster order.
  task automatic model_frame();
    for (int r = 0; r < OH; r++)
      for (int c = 0; c < OW; c++) begin
        longint s;
        s = bias;
        for (int i = 0; i < K; i++)
          for (int j = 0; j < K; j++) s += wts[i*K+j] * pix[(r+i)*IMG_W + c + j];
        if (RELU && s < 0) s = 0;
        exp_q.push_back(s);
      end
  endtask

  task automatic wait_out(input int n);
    int t;
    t = 0;
    while (obs_d.size() < n && t < 3000) begin
      tick();
      t++;
    end
    repeat (8) tick();
  endtask

  function automatic longint rnd16();
    logic signed [15:0] v;
    v = 16'($urandom);
    return longint'(v);
  endfunction

  task automatic test_reset();
    #1 rst_n = 1'b0;
    repeat (3) tick();
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b want 0", busy); end
    vectors++; if (w_err !== 1'b0) begin miscompares++; $display("FAIL reset_w_err got %b want 0", w_err); end
    vectors++; if (frame_done !== 1'b0) begin miscompares++; $display("FAIL reset_frame_done got %b want 0", frame_done); end
    vectors++; if (out_data !== '0) begin miscompares++; $display("FAIL reset_out_data got %0d want 0", out_data); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_ones_back_to_back();
    for (int n = 0; n < NT; n++) wts[n] = 1;
    bias = 0;
    for (int p = 0; p < NPIX; p++) pix[p] = 1;
    load_all();
    clear_logs();
    drive_frame(0, NPIX);
    drive_frame(0, NPIX);
    model_frame();
    model_frame();
    wait_out(2 * NOUT);
    vectors++;
    if (obs_d.size() !== exp_q.size()) begin miscompares++; $display("FAIL ones_count got %0d want %0d", obs_d.size(), exp_q.size()); end
    for (int k = 0; k < obs_d.size() && k < exp_q.size(); k++) begin
      int f, q, idx;
      f = k / NOUT; q = k % NOUT;
      idx = f * NPIX + (q / OW + K - 1) * IMG_W + q % OW + K - 1;
      vectors++; if (obs_d[k] !== exp_q[k]) begin miscompares++; $display("FAIL ones_data[%0d] got %0d want %0d", k, obs_d[k], exp_q[k]); end
      vectors++; if (obs_c[k] !== acc_c[idx] + 3) begin miscompares++; $display("FAIL ones_latency[%0d] got cycle %0d want %0d", k, obs_c[k], acc_c[idx] + 3); end
      vectors++; if (obs_f[k] !== (q == NOUT - 1)) begin miscompares++; $display("FAIL ones_frame_done[%0d] got %b want %b", k, obs_f[k], q == NOUT - 1); end
    end
    vectors++; if (stray_fd !== 0) begin miscompares++; $display("FAIL ones_stray_frame_done got %0d want 0", stray_fd); end
    vectors++; if (busy_rise !== acc_c[0] + 1) begin miscompares++; $display("FAIL ones_busy_rise got %0d want %0d", busy_rise, acc_c[0] + 1); end
    vectors++;
    if (obs_c.size() == 0 || busy_fall !== obs_c[obs_c.size()-1] + 1) begin
      miscompares++; $display("FAIL ones_busy_fall got %0d want one cycle after last frame_done", busy_fall);
    end
  endtask

  task automatic test_impulse(input int gap_max);
    for (int i = 0; i < K; i++) for (int j = 0; j < K; j++) wts[i*K+j] = i * 5 + j + 1;
    bias = 0;
    for (int p = 0; p < NPIX; p++) pix[p] = 0;
    pix[2*IMG_W+2] = 1;
    load_all();
    clear_logs();
    drive_frame(gap_max, NPIX);
    model_frame();
    wait_out(NOUT);
    vectors++;
    if (obs_d.size() !== NOUT) begin miscompares++; $display("FAIL impulse_count got %0d want %0d", obs_d.size(), NOUT); end
    for (int k = 0; k < obs_d.size() && k < exp_q.size(); k++) begin
      int idx;
      idx = (k / OW + K - 1) * IMG_W + k % OW + K - 1;
      vectors++; if (obs_d[k] !== exp_q[k]) begin miscompares++; $display("FAIL impulse_data[%0d] got %0d want %0d", k, obs_d[k], exp_q[k]); end
      vectors++; if (obs_c[k] !== acc_c[idx] + 3) begin miscompares++; $display("FAIL impulse_latency[%0d] got cycle %0d want %0d", k, obs_c[k], acc_c[idx] + 3); end
      vectors++; if (obs_f[k] !== (k == NOUT - 1)) begin miscompares++; $display("FAIL impulse_frame_done[%0d] got %b", k, obs_f[k]); end
    end
    if (obs_d.size() == NOUT) begin
      vectors++; if (obs_d[0] !== 13) begin miscompares++; $display("FAIL impulse_out00 got %0d want 13", obs_d[0]); end
      vectors++; if (obs_d[2*OW+2] !== 1) begin miscompares++; $display("FAIL impulse_out22 got %0d want 1", obs_d[2*OW+2]); end
      vectors++; if (obs_d[OW] !== 8) begin miscompares++; $display("FAIL impulse_out10 got %0d want 8", obs_d[OW]); end
    end
  endtask

  task automatic test_neg_bias();
    longint want;
    for (int n = 0; n < NT; n++) wts[n] = 1;
    bias = 3;
    for (int p = 0; p < NPIX; p++) pix[p] = -1;
    for (int n = 0; n < NT; n++) write_w(n, 1);
    clear_logs();
    // Bias lands in the same cycle as the frame's first pixel and must still apply.
    fork
      drive_frame(0, NPIX);
      write_w(NT, 3);
    join
    model_frame();
    wait_out(NOUT);
    want = RELU ? 0 : -22;
    vectors++; if (werr_cnt !== 0) begin miscompares++; $display("FAIL negbias_w_err got %0d pulses want 0", werr_cnt); end
    vectors++;
    if (obs_d.size() !== NOUT) begin miscompares++; $display("FAIL negbias_count got %0d want %0d", obs_d.size(), NOUT); end
    for (int k = 0; k < obs_d.size(); k++) begin
      vectors++; if (obs_d[k] !== want) begin miscompares++; $display("FAIL negbias_data[%0d] got %0d want %0d", k, obs_d[k], want); end
      vectors++; if (k < exp_q.size() && obs_d[k] !== exp_q[k]) begin miscompares++; $display("FAIL negbias_model[%0d] got %0d want %0d", k, obs_d[k], exp_q[k]); end
    end
  endtask

  task automatic test_werr();
    for (int n = 0; n < NT; n++) wts[n] = 1;
    bias = 0;
    for (int p = 0; p < NPIX; p++) pix[p] = 1;
    load_all();
    clear_logs();
    write_w(26, 999);
    tick();
    vectors++; if (werr_cnt !== 1) begin miscompares++; $display("FAIL werr_idle_addr got %0d pulses want 1", werr_cnt); end
    fork
      drive_frame(0, NPIX);
      begin
        repeat (100) tick();
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL werr_busy_mid_frame got %b want 1", busy); end
        write_w(0, 77);
        vectors++; if (w_err !== 1'b1) begin miscompares++; $display("FAIL werr_busy_pulse got %b want 1", w_err); end
        tick();
        vectors++; if (w_err !== 1'b0) begin miscompares++; $display("FAIL werr_pulse_width got %b want 0", w_err); end
      end
    join
    model_frame();
    wait_out(NOUT);
    vectors++; if (werr_cnt !== 2) begin miscompares++; $display("FAIL werr_total got %0d pulses want 2", werr_cnt); end
    vectors++;
    if (obs_d.size() !== NOUT) begin miscompares++; $display("FAIL werr_count got %0d want %0d", obs_d.size(), NOUT); end
    for (int k = 0; k < obs_d.size() && k < exp_q.size(); k++) begin
      vectors++; if (obs_d[k] !== 25) begin miscompares++; $display("FAIL werr_data[%0d] got %0d want 25", k, obs_d[k]); end
    end
  endtask

  task automatic test_random(input int gap_max);
    for (int n = 0; n < NT; n++) wts[n] = rnd16();
    bias = rnd16();
    for (int p = 0; p < NPIX; p++) pix[p] = rnd16();
    load_all();
    clear_logs();
    drive_frame(gap_max, NPIX);
    model_frame();
    wait_out(NOUT);
    vectors++;
    if (obs_d.size() !== NOUT) begin miscompares++; $display("FAIL random_count got %0d want %0d", obs_d.size(), NOUT); end
    for (int k = 0; k < obs_d.size() && k < exp_q.size(); k++) begin
      int idx;
      idx = (k / OW + K - 1) * IMG_W + k % OW + K - 1;
      vectors++; if (obs_d[k] !== exp_q[k]) begin miscompares++; $display("FAIL random_data[%0d] got %0d want %0d", k, obs_d[k], exp_q[k]); end
      vectors++; if (obs_c[k] !== acc_c[idx] + 3) begin miscompares++; $display("FAIL random_latency[%0d] got cycle %0d want %0d", k, obs_c[k], acc_c[idx] + 3); end
      vectors++; if (obs_f[k] !== (k == NOUT - 1)) begin miscompares++; $display("FAIL random_frame_done[%0d] got %b", k, obs_f[k]); end
    end
  endtask

  task automatic test_mid_reset();
    int n_before;
    clear_logs();
    drive_frame(0, 300);
    rst_n = 1'b0;
    n_before = obs_d.size();
    repeat (3) tick();
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL midrst_out_valid got %b want 0", out_valid); end
    vectors++; if (out_data !== '0) begin miscompares++; $display("FAIL midrst_out_data got %0d want 0", out_data); end
    rst_n = 1'b1;
    repeat (20) tick();
    vectors++; if (obs_d.size() !== n_before) begin miscompares++; $display("FAIL midrst_extra_outputs got %0d want %0d", obs_d.size(), n_before); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL midrst_busy got %b want 0", busy); end
    // Without a reload every coefficient and the bias are zero.
    for (int p = 0; p < NPIX; p++) pix[p] = rnd16();
    clear_logs();
    drive_frame(0, NPIX);
    wait_out(NOUT);
    vectors++;
    if (obs_d.size() !== NOUT) begin miscompares++; $display("FAIL midrst_zero_count got %0d want %0d", obs_d.size(), NOUT); end
    for (int k = 0; k < obs_d.size(); k++) begin
      vectors++; if (obs_d[k] !== 0) begin miscompares++; $display("FAIL midrst_zero_data[%0d] got %0d want 0", k, obs_d[k]); end
    end
    test_random(0);
  endtask

  initial begin
    test_reset();
    test_ones_back_to_back();
    test_impulse(0);
    test_impulse(4);
    test_neg_bias();
    test_werr();
    test_random(2);
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
